// File: rtl/jedro_1_lsu_pkg.sv
// Shared types and constants for the jedro_1 load-store unit: FSM state
// encodings, access width codes and the load extension helper.
package jedro_1_lsu_pkg;

  localparam int XLEN            = 32;
  localparam int LSU_WIDTH_WIDTH = 2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_RESP = 2'b11
  } lsu_state_e;

  localparam logic [LSU_WIDTH_WIDTH-1:0] LSU_BYTE = 2'b00;
  localparam logic [LSU_WIDTH_WIDTH-1:0] LSU_HALF = 2'b01;
  localparam logic [LSU_WIDTH_WIDTH-1:0] LSU_WORD = 2'b10;

  // Sign- or zero-extend the low byte (half=0) or low halfword (half=1).
  function automatic logic [XLEN-1:0] lsu_extend(input logic [15:0] v,
                                                 input logic        half,
                                                 input logic        zext);
    logic [XLEN-1:0] r;
    if (half) r = zext ? {16'h0000, v} : {{16{v[15]}}, v};
    else      r = zext ? {24'h000000, v[7:0]} : {{24{v[7]}}, v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// Core data bus (req/gnt/rvalid handshake) between the LSU and data memory.
interface jedro_1_lsu_if;

  logic                               req;
  logic                               gnt;
  logic                               rvalid;
  logic                               we;
  logic [3:0]                         be;
  logic [jedro_1_lsu_pkg::XLEN-1:0]   addr;
  logic [jedro_1_lsu_pkg::XLEN-1:0]   wdata;
  logic [jedro_1_lsu_pkg::XLEN-1:0]   rdata;
  logic                               err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/jedro_1_lsu_align.sv
// Combinational lane logic: byte enables, store data replication,
// misalignment detection and load shift/extend.
module jedro_1_lsu_align
  import jedro_1_lsu_pkg::*;
(
  input  logic [1:0]                 addr_lsb_i,
  input  logic [LSU_WIDTH_WIDTH-1:0] width_i,
  input  logic                       zext_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [XLEN-1:0]            rdata_i,
  output logic [3:0]                 be_o,
  output logic [XLEN-1:0]            wdata_o,
  output logic                       misaligned_o,
  output logic [XLEN-1:0]            rdata_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {addr_lsb_i, 3'b000};

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    rdata_o      = shifted;
    case (width_i)
      LSU_BYTE: begin
        be_o    = 4'b0001 << addr_lsb_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = lsu_extend(shifted[15:0], 1'b0, zext_i);
      end
      LSU_HALF: begin
        be_o         = 4'b0011 << {addr_lsb_i[1], 1'b0};
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lsb_i[0];
        rdata_o      = lsu_extend(shifted[15:0], 1'b1, zext_i);
      end
      LSU_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lsb_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: one command at a time over the req/gnt/rvalid bus.
// Optional watchdog enabled by defining JEDRO_1_LSU_TIMEOUT_EN.
module jedro_1_lsu
  import jedro_1_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [LSU_WIDTH_WIDTH-1:0] cmd_width_i,
  input  logic                       cmd_unsigned_i,
  input  logic [DATA_WIDTH-1:0]      cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0]  cmd_rd_addr_i,
  output logic                       rsp_valid_o,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic [REG_ADDR_WIDTH-1:0]  rsp_rd_addr_o,
  output logic                       rsp_wb_o,
  output logic                       rsp_err_o,
  output logic                       rsp_misaligned_o,
  jedro_1_lsu_if.master              data_if
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : gBadConfig
    $error("jedro_1_lsu: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
  end

  lsu_state_e                 state_q;
  logic [DATA_WIDTH-1:0]      addr_q;
  logic [LSU_WIDTH_WIDTH-1:0] width_q;
  logic                       we_q;
  logic                       zext_q;
  logic [REG_ADDR_WIDTH-1:0]  rd_q;
  logic [3:0]                 be_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic                       err_q;
  logic                       mis_q;
  logic                       wb_q;

  logic                       isIdle;
  logic                       isReq;
  logic                       isResp;
  logic [1:0]                 alignAddr;
  logic [LSU_WIDTH_WIDTH-1:0] alignWidth;
  logic                       alignZext;
  logic [3:0]                 alignBe;
  logic [DATA_WIDTH-1:0]      alignWdata;
  logic                       alignMis;
  logic [DATA_WIDTH-1:0]      alignRdata;
  logic                       timeout;

  assign isIdle = (state_q == LSU_IDLE);
  assign isReq  = (state_q == LSU_REQ);
  assign isResp = (state_q == LSU_RESP);

  // One aligner serves both phases: the incoming command while idle, the
  // captured command once the read data comes back.
  assign alignAddr  = isIdle ? cmd_addr_i[1:0] : addr_q[1:0];
  assign alignWidth = isIdle ? cmd_width_i     : width_q;
  assign alignZext  = isIdle ? cmd_unsigned_i  : zext_q;

  jedro_1_lsu_align u_align (
    .addr_lsb_i   (alignAddr),
    .width_i      (alignWidth),
    .zext_i       (alignZext),
    .wdata_i      (cmd_wdata_i),
    .rdata_i      (data_if.rdata),
    .be_o         (alignBe),
    .wdata_o      (alignWdata),
    .misaligned_o (alignMis),
    .rdata_o      (alignRdata)
  );

`ifdef JEDRO_1_LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      rd_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      wb_q    <= 1'b0;
`ifdef JEDRO_1_LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            width_q <= cmd_width_i;
            we_q    <= cmd_we_i;
            zext_q  <= cmd_unsigned_i;
            rd_q    <= cmd_rd_addr_i;
            be_q    <= alignBe;
            wdata_q <= alignWdata;
            rdata_q <= '0;
            wb_q    <= 1'b0;
            err_q   <= alignMis;
            mis_q   <= alignMis;
            state_q <= alignMis ? LSU_RESP : LSU_REQ;
`ifdef JEDRO_1_LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        LSU_REQ: begin
`ifdef JEDRO_1_LSU_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
`endif
          if (data_if.gnt) begin
            state_q <= LSU_WAIT;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= LSU_RESP;
          end
        end
        LSU_WAIT: begin
`ifdef JEDRO_1_LSU_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
`endif
          if (data_if.rvalid) begin
            err_q   <= data_if.err;
            rdata_q <= (we_q || data_if.err) ? '0 : alignRdata;
            wb_q    <= !we_q && !data_if.err && (|rd_q);
            state_q <= LSU_RESP;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= LSU_RESP;
          end
        end
        LSU_RESP: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = isIdle;

  assign data_if.req      = isReq;
  assign data_if.we       = isReq & we_q;
  assign data_if.be       = isReq ? be_q : 4'b0000;
  assign data_if.addr     = isReq ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign data_if.wdata    = isReq ? wdata_q : '0;

  assign rsp_valid_o      = isResp;
  assign rsp_rdata_o      = isResp ? rdata_q : '0;
  assign rsp_rd_addr_o    = isResp ? rd_q : '0;
  assign rsp_wb_o         = isResp & wb_q;
  assign rsp_err_o        = isResp & err_q;
  assign rsp_misaligned_o = isResp & mis_q;

endmodule
